// File: rtl/gb_fb_pkg.sv
// Shared constants and types for the Game Boy frame-buffer write side.
// Pure declarations, no logic.
package gb_fb_pkg;

    localparam int LCD_W      = 160;
    localparam int LCD_H      = 144;
    localparam int FB_PIXELS  = LCD_W * LCD_H;
    localparam int PIX_ADDR_W = 15;

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        SWAP_PEND = 1'b1
    } fb_state_e;

    typedef logic [PIX_ADDR_W-1:0] pix_addr_t;

endpackage

// File: rtl/gb_fb_pix_counter.sv
// Wrapping pixel counter 0..FB_PIXELS-1 with frame-sync restart; updates 1 cycle after adv/sync.
// No backpressure: every asserted adv_i advances the count.
module gb_fb_pix_counter #(
    parameter int FB_PIXELS = gb_fb_pkg::FB_PIXELS,
    parameter int ADDR_W    = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sync_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] pix_o,
    output logic              last_o
);
    import gb_fb_pkg::*;

    logic [ADDR_W-1:0] pix_q, pix_d;

    assign pix_o  = pix_q;
    assign last_o = (pix_q == ADDR_W'(FB_PIXELS - 1));

    // A pixel arriving with sync lands on address 0, so the count resumes at 1.
    always_comb begin
        pix_d = pix_q;
        if (sync_i) begin
            pix_d = adv_i ? ADDR_W'(1) : '0;
        end else if (adv_i) begin
            pix_d = last_o ? '0 : pix_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pix_q <= '0;
        else       pix_q <= pix_d;
    end

endmodule

// File: rtl/gb_fb_write_ctrl.sv
// PPU/host frame-buffer write controller with bank swap on blanking (FB_DOUBLE_BUFFER_EN); writes 1 cycle after accept.
// PPU is never stalled; host_req is starved while px_valid streams and granted combinationally otherwise.
module gb_fb_write_ctrl #(
    parameter int FB_PIXELS = 23040,
    parameter int ADDR_W    = 15,
    parameter int DROP_W    = 8
) (
    input  logic              GameBoy_clk,
    input  logic              GameBoy_reset,
    input  logic              px_valid,
    input  logic [1:0]        px_data,
    input  logic              frame_sync,
    input  logic              disp_vblank,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [1:0]        host_data,
    output logic              host_gnt,
    output logic              fb_we,
    output logic [ADDR_W:0]   fb_waddr,
    output logic [1:0]        fb_wdata,
    output logic              disp_bank,
    output logic              frame_done,
    output logic [DROP_W-1:0] drop_cnt
);
    import gb_fb_pkg::*;

    fb_state_e          state_q;
    logic [ADDR_W-1:0]  pix, px_addr;
    logic               pix_last, back_bank, gnt, host_ok, drop_evt;
    logic               fb_we_q, disp_bank_q, frame_done_q;
    logic [ADDR_W:0]    fb_waddr_q;
    logic [1:0]         fb_wdata_q;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

    gb_fb_pix_counter #(
        .FB_PIXELS (FB_PIXELS),
        .ADDR_W    (ADDR_W)
    ) u_pix (
        .clk_i  (GameBoy_clk),
        .rst_i  (GameBoy_reset),
        .sync_i (frame_sync),
        .adv_i  (px_valid),
        .pix_o  (pix),
        .last_o (pix_last)
    );

    always_comb begin
`ifdef FB_DOUBLE_BUFFER_EN
        back_bank = ~disp_bank_q;
`else
        back_bank = 1'b0;
`endif
        px_addr  = frame_sync ? '0 : pix;
        gnt      = host_req & ~px_valid;
        host_ok  = (host_addr < ADDR_W'(FB_PIXELS));
        // In SWAP_PEND the counter has already wrapped, so any new pixel abandons the swap.
        drop_evt = (state_q == FILL) ? (frame_sync && (pix != '0)) : px_valid;
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end

    always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
        if (GameBoy_reset) begin
            state_q      <= FILL;
            fb_we_q      <= 1'b0;
            fb_waddr_q   <= '0;
            fb_wdata_q   <= '0;
            disp_bank_q  <= 1'b0;
            frame_done_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            fb_we_q      <= px_valid | (gnt & host_ok);
            frame_done_q <= 1'b0;
            drop_cnt_q   <= drop_cnt_d;
            if (px_valid) begin
                fb_waddr_q <= {back_bank, px_addr};
                fb_wdata_q <= px_data;
            end else if (gnt) begin
                fb_waddr_q <= {back_bank, host_addr};
                fb_wdata_q <= host_data;
            end
            case (state_q)
                FILL: begin
                    if (px_valid && pix_last && !frame_sync) begin
`ifdef FB_DOUBLE_BUFFER_EN
                        state_q <= SWAP_PEND;
`else
                        frame_done_q <= 1'b1;
`endif
                    end
                end
                SWAP_PEND: begin
                    state_q <= px_valid ? FILL : (disp_vblank ? FILL : SWAP_PEND);
                    if (!px_valid && disp_vblank) begin
                        frame_done_q <= 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
                        disp_bank_q  <= ~disp_bank_q;
`endif
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign host_gnt   = gnt & ~GameBoy_reset;
    assign fb_we      = fb_we_q;
    assign fb_waddr   = fb_waddr_q;
    assign fb_wdata   = fb_wdata_q;
    assign disp_bank  = disp_bank_q;
    assign frame_done = frame_done_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_gb_fb_write_ctrl.sv
// Directed bench for gb_fb_write_ctrl; expectations follow FB_DOUBLE_BUFFER_EN when defined.
module tb_gb_fb_write_ctrl;

    localparam int NPIX = 23040;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam logic [15:0] B = DB ? 16'h8000 : 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        px_valid, frame_sync, disp_vblank, host_req;
    logic [1:0]  px_data, host_data;
    logic [14:0] host_addr;
    logic        host_gnt, fb_we, disp_bank, frame_done;
    logic [15:0] fb_waddr;
    logic [1:0]  fb_wdata;
    logic [7:0]  drop_cnt;

    int n_vec = 0;
    int n_err = 0;
    int bad, dcnt, dlast;

    always #5 clk = ~clk;

    gb_fb_write_ctrl dut (
        .GameBoy_clk   (clk),
        .GameBoy_reset (rst),
        .px_valid      (px_valid),
        .px_data       (px_data),
        .frame_sync    (frame_sync),
        .disp_vblank   (disp_vblank),
        .host_req      (host_req),
        .host_addr     (host_addr),
        .host_data     (host_data),
        .host_gnt      (host_gnt),
        .fb_we         (fb_we),
        .fb_waddr      (fb_waddr),
        .fb_wdata      (fb_wdata),
        .disp_bank     (disp_bank),
        .frame_done    (frame_done),
        .drop_cnt      (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        px_valid = 0; px_data = 0; frame_sync = 0; disp_vblank = 0;
        host_req = 0; host_addr = 0; host_data = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    // Streams n pixels of shade 2 from the current counter position (assumed 0).
    task automatic run_frame(input int n, output int addr_bad, output int done_cnt, output int done_last);
        addr_bad = 0; done_cnt = 0; done_last = 0;
        for (int i = 0; i < n; i++) begin
            px_valid = 1; px_data = 2'b10;
            tick();
            if (fb_we !== 1'b1 || fb_waddr !== (B + 16'(i)) || fb_wdata !== 2'b10) addr_bad++;
            if (frame_done === 1'b1) begin
                done_cnt++;
                if (i == n - 1) done_last = 1;
            end
        end
        px_valid = 0;
    endtask

    initial begin
        // Reset values
        px_valid = 0; px_data = 0; frame_sync = 0; disp_vblank = 0;
        host_req = 0; host_addr = 0; host_data = 0;
        rst = 1;
        #12;
        chk("rst_we", fb_we, 0);
        chk("rst_waddr", fb_waddr, 0);
        chk("rst_wdata", fb_wdata, 0);
        chk("rst_bank", disp_bank, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_gnt", host_gnt, 0);
        rst = 0;
        tick();

        // Full frame then blanking
        run_frame(NPIX, bad, dcnt, dlast);
        chk("frame_addr_bad", bad, 0);
        chk("frame_done_cnt", dcnt, DB ? 0 : 1);
        chk("frame_done_last", dlast, DB ? 0 : 1);
        tick();
        chk("idle_done", frame_done, 0);
        chk("pre_swap_bank", disp_bank, 0);
        disp_vblank = 1;
        tick();
        chk("swap_bank", disp_bank, DB);
        chk("swap_done", frame_done, DB);
        disp_vblank = 0;
        tick();
        chk("swap_done_clr", frame_done, 0);
        chk("swap_bank_hold", disp_bank, DB);
        px_valid = 1; px_data = 2'b01;
        tick();
        px_valid = 0;
        chk("post_swap_addr", fb_waddr, 16'h0000);
        chk("post_swap_drop", drop_cnt, 0);

        // Reset returns bank; missed blanking drops the frame
        do_reset();
        chk("bank_after_rst", disp_bank, 0);
        run_frame(NPIX, bad, dcnt, dlast);
        chk("frame2_addr_bad", bad, 0);
        repeat (3) tick();
        chk("pend_bank", disp_bank, 0);
        px_valid = 1; px_data = 2'b01;
        tick();
        chk("drop_addr", fb_waddr, B);
        chk("drop_cnt1", drop_cnt, DB ? 1 : 0);
        tick();
        chk("drop_next_addr", fb_waddr, B + 16'd1);
        px_valid = 0; disp_vblank = 1;
        tick();
        disp_vblank = 0;
        chk("no_swap_bank", disp_bank, 0);
        chk("no_swap_done", frame_done, 0);

        // Host arbitration
        do_reset();
        host_req = 1; host_addr = 15'd100; host_data = 2'b11;
        px_valid = 1; px_data = 2'b01;
        #1 chk("gnt_c1", host_gnt, 0);
        tick();
        chk("px_c1_addr", fb_waddr, B);
        #1 chk("gnt_c2", host_gnt, 0);
        tick();
        px_valid = 0;
        #1 chk("gnt_c3", host_gnt, 1);
        tick();
        host_req = 0;
        chk("host_we", fb_we, 1);
        chk("host_addr", fb_waddr, B + 16'd100);
        chk("host_data", fb_wdata, 2'b11);
        #1 chk("gnt_drop", host_gnt, 0);
        host_req = 1; host_addr = 15'd23040;
        #1 chk("gnt_oor", host_gnt, 1);
        tick();
        host_req = 0;
        chk("oor_we", fb_we, 0);

        // frame_sync mid-frame
        do_reset();
        frame_sync = 1;
        tick();
        frame_sync = 0;
        chk("sync_at0_drop", drop_cnt, 0);
        chk("sync_at0_we", fb_we, 0);
        run_frame(500, bad, dcnt, dlast);
        chk("p500_addr_bad", bad, 0);
        frame_sync = 1; px_valid = 1; px_data = 2'b11;
        tick();
        frame_sync = 0;
        chk("sync_px_addr", fb_waddr, B);
        chk("sync_px_data", fb_wdata, 2'b11);
        chk("sync_drop", drop_cnt, 1);
        tick();
        px_valid = 0;
        chk("sync_next_addr", fb_waddr, B + 16'd1);

        // Saturation of drop_cnt
        for (int i = 0; i < 260; i++) begin
            px_valid = 1;
            tick();
            px_valid = 0; frame_sync = 1;
            tick();
            frame_sync = 0;
            if (i == 252) chk("drop_254", drop_cnt, 254);
            if (i == 253) chk("drop_255", drop_cnt, 255);
        end
        chk("drop_sat", drop_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
